// File: rtl/piece_lock.sv
// piece_lock: merges a landed tetromino into a board snapshot, flags full rows and presents the result with a one-cycle update pulse.
// Optional feature macro: PIECE_LOCK_SCORE_EN adds a saturating 20-bit score output.
`default_nettype none

module piece_lock #(
  parameter int ROWS  = 22,
  parameter int COLS  = 12,
  parameter int CELLS = 4
) (
  input  logic                   vsync,
  input  logic                   reset_n,
  input  logic                   lock_req,
  input  logic [5*CELLS-1:0]     piece_row,
  input  logic [4*CELLS-1:0]     piece_col,
  input  logic [COLS*ROWS-1:0]   in_row_contents,
  output logic                   busy,
  output logic [COLS*ROWS-1:0]   row_contents,
  output logic                   update,
  output logic [ROWS-1:0]        full_mask,
  output logic [2:0]             full_count,
  output logic                   collision
`ifdef PIECE_LOCK_SCORE_EN
  ,
  output logic [19:0]            score
`endif
);

  localparam int KW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [COLS-1:0] c_SOLID = '1;
  localparam logic [COLS-1:0] c_WALL  = {1'b1, {(COLS-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [COLS-1:0]       r_board    [ROWS];
  logic [4:0]            r_cell_row [CELLS];
  logic [3:0]            r_cell_col [CELLS];
  logic [KW-1:0]         r_k;
  logic                  r_busy;
  logic                  r_update;
  logic                  r_collision;
  logic [ROWS-1:0]       r_full_mask;
  logic [2:0]            r_full_count;
  logic [COLS*ROWS-1:0]  r_row_contents;

  logic [4:0]            w_row;
  logic [3:0]            w_col;
  logic                  w_in_range;
  logic [4:0]            w_row_idx;
  logic [3:0]            w_col_idx;
  logic                  w_cell_ok;
  logic [ROWS-1:0]       w_mask;
  logic [2:0]            w_count;

  assign w_row      = r_cell_row[r_k];
  assign w_col      = r_cell_col[r_k];
  assign w_in_range = (w_row >= 5'd1) && (w_row <= 5'(ROWS-2)) &&
                      (w_col >= 4'd1) && (w_col <= 4'(COLS-2));
  // Out-of-range coordinates are steered to a safe index; the cell is rejected anyway.
  assign w_row_idx  = w_in_range ? w_row : 5'd0;
  assign w_col_idx  = w_in_range ? w_col : 4'd0;
  assign w_cell_ok  = w_in_range && !r_board[w_row_idx][w_col_idx];

  always_comb begin
    w_mask  = '0;
    w_count = '0;
    for (int r = 1; r < ROWS-1; r++) begin
      w_mask[r] = (r_board[r] == c_SOLID);
      w_count   = w_count + 3'(w_mask[r]);
    end
  end

`ifdef PIECE_LOCK_SCORE_EN
  logic [19:0] r_score;
  logic [19:0] w_points;
  logic [20:0] w_score_sum;

  always_comb begin
    case (r_full_count)
      3'd1:    w_points = 20'd40;
      3'd2:    w_points = 20'd100;
      3'd3:    w_points = 20'd300;
      3'd4:    w_points = 20'd1200;
      default: w_points = 20'd0;
    endcase
    if (r_collision) w_points = 20'd0;
  end

  assign w_score_sum = {1'b0, r_score} + {1'b0, w_points};
  assign score       = r_score;

  always_ff @(posedge vsync or negedge reset_n) begin
    if (!reset_n) begin
      r_score <= '0;
    end else if (r_state == S_DONE) begin
      r_score <= w_score_sum[20] ? 20'hFFFFF : w_score_sum[19:0];
    end
  end
`endif

  always_ff @(posedge vsync or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_busy       <= 1'b0;
      r_update     <= 1'b0;
      r_collision  <= 1'b0;
      r_full_mask  <= '0;
      r_full_count <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_board[r]                        <= (r == 0 || r == ROWS-1) ? c_SOLID : c_WALL;
        r_row_contents[r*COLS +: COLS]    <= (r == 0 || r == ROWS-1) ? c_SOLID : c_WALL;
      end
      for (int k = 0; k < CELLS; k++) begin
        r_cell_row[k] <= '0;
        r_cell_col[k] <= '0;
      end
    end else begin
      r_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lock_req) begin
            for (int k = 0; k < CELLS; k++) begin
              r_cell_row[k] <= piece_row[k*5 +: 5];
              r_cell_col[k] <= piece_col[k*4 +: 4];
            end
            for (int r = 0; r < ROWS; r++) begin
              r_board[r] <= (r == 0 || r == ROWS-1) ? c_SOLID
                                                    : (in_row_contents[r*COLS +: COLS] | c_WALL);
            end
            r_collision <= 1'b0;
            r_k         <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_cell_ok) begin
            r_board[w_row_idx][w_col_idx] <= 1'b1;
          end else begin
            r_collision <= 1'b1;
          end
          if (r_k == KW'(CELLS-1)) begin
            r_state <= S_SCAN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_SCAN: begin
          r_full_mask  <= w_mask;
          r_full_count <= w_count;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          for (int r = 0; r < ROWS; r++) begin
            r_row_contents[r*COLS +: COLS] <= r_board[r];
          end
          r_update <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign update       = r_update;
  assign collision    = r_collision;
  assign full_mask    = r_full_mask;
  assign full_count   = r_full_count;
  assign row_contents = r_row_contents;

endmodule

`default_nettype wire
